// File: rtl/ram_wordline_decode_ctrl.sv
// Wordline front end for the partitioned register/RAM arrays: binary-to-one-hot
// read/write selects with per-partition power gating and not-ready stall detection.
//
// state     | meaning
// PART_ON   | partition powered, accepts accesses once ramReady_i is high
// PART_OFF  | partition power-gated, all accesses stall
// PART_WAKE | ungated, settling for WAKE_CYCLES cycles before accepting accesses
module ram_wordline_decode_ctrl #(
    parameter int DEPTH         = 64,
    parameter int INDEX         = 6,
    parameter int NUM_RD_PORTS  = 4,
    parameter int NUM_WR_PORTS  = 2,
    parameter int NUM_PARTS     = 4,
    parameter int NUM_PARTS_LOG = 2,
    parameter int WAKE_CYCLES   = 4
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [NUM_RD_PORTS-1:0][INDEX-1:0]            rdAddr_i,
    input  logic [NUM_RD_PORTS-1:0]                       rdEn_i,
    input  logic [NUM_WR_PORTS-1:0][INDEX-1:0]            wrAddr_i,
    input  logic [NUM_WR_PORTS-1:0]                       wrEn_i,
    input  logic [NUM_PARTS-1:0]                          partGateReq_i,
    input  logic                                          ramReady_i,
    output logic [NUM_RD_PORTS-1:0][DEPTH-1:0]            addr_o,
    output logic [NUM_RD_PORTS-1:0][NUM_PARTS_LOG-1:0]    rdDataPartition_o,
    output logic [NUM_WR_PORTS-1:0][DEPTH-1:0]            addrWr_o,
    output logic [NUM_WR_PORTS-1:0]                       wrEn_o,
    output logic [NUM_PARTS-1:0]                          partitionGated_o,
    output logic [NUM_PARTS-1:0]                          partReady_o,
    output logic                                          accessStall_o
);

    localparam int CNT_W = $clog2(WAKE_CYCLES) + 1;

    typedef enum logic [1:0] {
        PART_ON   = 2'd0,
        PART_OFF  = 2'd1,
        PART_WAKE = 2'd2
    } partState_t;

    partState_t       partState    [NUM_PARTS];
    partState_t       partStateNxt [NUM_PARTS];
    logic [CNT_W-1:0] wakeCnt      [NUM_PARTS];
    logic [CNT_W-1:0] wakeCntNxt   [NUM_PARTS];

    logic [NUM_RD_PORTS-1:0] rdGo;
    logic [NUM_WR_PORTS-1:0] wrGo;
    logic [NUM_PARTS-1:0]    partTouched;

    function automatic logic [NUM_PARTS_LOG-1:0] partOf(input logic [INDEX-1:0] idx);
        return idx[INDEX-1 -: NUM_PARTS_LOG];
    endfunction

    always_comb begin
        for (int p = 0; p < NUM_PARTS; p++) begin
            partReady_o[p]      = (partState[p] == PART_ON) && ramReady_i;
            partitionGated_o[p] = (partState[p] == PART_OFF);
        end
    end

    // Any enabled request marks its partition as touched, even when it stalls,
    // so a gate request cannot pull a partition out from under a pending access.
    always_comb begin
        rdGo          = '0;
        wrGo          = '0;
        partTouched   = '0;
        accessStall_o = 1'b0;
        for (int r = 0; r < NUM_RD_PORTS; r++) begin
            if (rdEn_i[r]) begin
                partTouched[partOf(rdAddr_i[r])] = 1'b1;
                if (partReady_o[partOf(rdAddr_i[r])]) rdGo[r] = 1'b1;
                else                                  accessStall_o = 1'b1;
            end
        end
        for (int w = 0; w < NUM_WR_PORTS; w++) begin
            if (wrEn_i[w]) begin
                partTouched[partOf(wrAddr_i[w])] = 1'b1;
                if (partReady_o[partOf(wrAddr_i[w])]) wrGo[w] = 1'b1;
                else                                  accessStall_o = 1'b1;
            end
        end
        for (int w = 0; w < NUM_WR_PORTS; w++) begin
            for (int v = w + 1; v < NUM_WR_PORTS; v++) begin
                if (wrEn_i[w] && wrEn_i[v] && (wrAddr_i[w] == wrAddr_i[v])) wrGo[w] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_o            <= '0;
            addrWr_o          <= '0;
            wrEn_o            <= '0;
            rdDataPartition_o <= '0;
        end else begin
            for (int r = 0; r < NUM_RD_PORTS; r++) begin
                addr_o[r] <= rdGo[r] ? (DEPTH'(1) << rdAddr_i[r]) : '0;
                if (rdEn_i[r]) rdDataPartition_o[r] <= partOf(rdAddr_i[r]);
            end
            for (int w = 0; w < NUM_WR_PORTS; w++) begin
                addrWr_o[w] <= wrGo[w] ? (DEPTH'(1) << wrAddr_i[w]) : '0;
            end
            wrEn_o <= wrGo;
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PARTS; p++) begin
            partStateNxt[p] = partState[p];
            wakeCntNxt[p]   = wakeCnt[p];
            case (partState[p])
                PART_ON: begin
                    if (partGateReq_i[p] && !partTouched[p]) partStateNxt[p] = PART_OFF;
                end
                PART_OFF: begin
                    if (!partGateReq_i[p]) begin
                        partStateNxt[p] = PART_WAKE;
                        wakeCntNxt[p]   = CNT_W'(WAKE_CYCLES - 1);
                    end
                end
                PART_WAKE: begin
                    if (partGateReq_i[p]) begin
                        partStateNxt[p] = PART_OFF;
                        wakeCntNxt[p]   = '0;
                    end else if (wakeCnt[p] == '0) begin
                        partStateNxt[p] = PART_ON;
                    end else begin
                        wakeCntNxt[p] = wakeCnt[p] - CNT_W'(1);
                    end
                end
                default: begin
                    partStateNxt[p] = PART_ON;
                    wakeCntNxt[p]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NUM_PARTS; p++) begin
                partState[p] <= PART_ON;
                wakeCnt[p]   <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PARTS; p++) begin
                partState[p] <= partStateNxt[p];
                wakeCnt[p]   <= wakeCntNxt[p];
            end
        end
    end

endmodule

// File: tb/tb_ram_wordline_decode_ctrl.sv
// Directed bench for ram_wordline_decode_ctrl: decode, collision, gating,
// wake timing and asynchronous reset, with hand-computed expectations.
module tb_ram_wordline_decode_ctrl;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0][5:0]  rdAddr;
    logic [3:0]       rdEn;
    logic [1:0][5:0]  wrAddr;
    logic [1:0]       wrEn;
    logic [3:0]       partGateReq;
    logic             ramReady;
    logic [3:0][63:0] addrO;
    logic [3:0][1:0]  rdPart;
    logic [1:0][63:0] addrWrO;
    logic [1:0]       wrEnO;
    logic [3:0]       gated;
    logic [3:0]       ready;
    logic             stall;

    int errors = 0;
    int checks = 0;

    ram_wordline_decode_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .rdAddr_i          (rdAddr),
        .rdEn_i            (rdEn),
        .wrAddr_i          (wrAddr),
        .wrEn_i            (wrEn),
        .partGateReq_i     (partGateReq),
        .ramReady_i        (ramReady),
        .addr_o            (addrO),
        .rdDataPartition_o (rdPart),
        .addrWr_o          (addrWrO),
        .wrEn_o            (wrEnO),
        .partitionGated_o  (gated),
        .partReady_o       (ready),
        .accessStall_o     (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] oh(input int idx);
        return 64'd1 << idx;
    endfunction

    initial begin
        reset       = 1'b0;
        rdAddr      = '0;
        rdEn        = '0;
        wrAddr      = '0;
        wrEn        = '0;
        partGateReq = '0;
        ramReady    = 1'b0;
        tick();
        tick();
        chk("rst_addr",    64'(addrO),   64'd0);
        chk("rst_addrWr",  64'(addrWrO), 64'd0);
        chk("rst_wrEn",    64'(wrEnO),   64'd0);
        chk("rst_rdPart",  64'(rdPart),  64'd0);
        chk("rst_gated",   64'(gated),   64'd0);
        chk("rst_ready",   64'(ready),   64'd0);

        // RAM not ready yet: any valid request stalls
        reset = 1'b1;
        rdEn[0] = 1'b1; rdAddr[0] = 6'd3;
        #1;
        chk("notready_stall", 64'(stall), 64'd1);
        tick();
        chk("notready_addr0", addrO[0], 64'd0);

        ramReady = 1'b1;
        rdEn[0] = 1'b1; rdAddr[0] = 6'd37;
        #1;
        chk("ready_all", 64'(ready), 64'hF);
        chk("rd37_stall", 64'(stall), 64'd0);
        tick();
        chk("rd37_addr0", addrO[0], oh(37));
        chk("rd37_part0", 64'(rdPart[0]), 64'd2);

        rdEn = '0;
        tick();
        chk("rdoff_addr0", addrO[0], 64'd0);
        chk("rdoff_part_hold", 64'(rdPart[0]), 64'd2);

        wrEn = 2'b11; wrAddr[0] = 6'd5; wrAddr[1] = 6'd5;
        tick();
        chk("coll_wrEn", 64'(wrEnO), 64'h2);
        chk("coll_addrWr1", addrWrO[1], oh(5));
        chk("coll_addrWr0", addrWrO[0], 64'd0);

        wrAddr[0] = 6'd10; wrAddr[1] = 6'd63;
        rdEn = 4'b1111;
        rdAddr[0] = 6'd0; rdAddr[1] = 6'd16; rdAddr[2] = 6'd32; rdAddr[3] = 6'd63;
        tick();
        chk("dual_wrEn", 64'(wrEnO), 64'h3);
        chk("dual_addrWr0", addrWrO[0], oh(10));
        chk("dual_addrWr1", addrWrO[1], oh(63));
        chk("quad_addr1", addrO[1], oh(16));
        chk("quad_addr3", addrO[3], oh(63));
        chk("quad_parts", 64'(rdPart), 64'hE4);

        // gate partition 1 with no traffic to it
        rdEn = '0; wrEn = '0;
        partGateReq[1] = 1'b1;
        tick();
        chk("gate1_gated", 64'(gated), 64'h2);
        chk("gate1_ready", 64'(ready), 64'hD);

        rdEn[0] = 1'b1; rdAddr[0] = 6'd20;
        #1;
        chk("gated_rd20_stall", 64'(stall), 64'd1);
        tick();
        chk("gated_rd20_addr0", addrO[0], 64'd0);
        chk("gated_rd20_still_off", 64'(gated[1]), 64'd1);

        rdEn = '0;
        partGateReq[1] = 1'b0;
        tick();
        chk("wake_gated", 64'(gated[1]), 64'd0);
        chk("wake_c0_ready", 64'(ready[1]), 64'd0);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk($sformatf("wake_c%0d_ready", i), 64'(ready[1]), 64'd0);
        end
        tick();
        chk("wake_done_ready", 64'(ready[1]), 64'd1);

        rdEn[0] = 1'b1; rdAddr[0] = 6'd20;
        #1;
        chk("rd20_stall", 64'(stall), 64'd0);
        tick();
        chk("rd20_addr0", addrO[0], oh(20));
        chk("rd20_part0", 64'(rdPart[0]), 64'd1);

        // gate request racing a write to partition 3
        rdEn = '0;
        wrEn = 2'b01; wrAddr[0] = 6'd50;
        partGateReq[3] = 1'b1;
        tick();
        chk("gate3_busy_gated", 64'(gated[3]), 64'd0);
        chk("gate3_busy_wrEn", 64'(wrEnO), 64'h1);
        chk("gate3_busy_addrWr0", addrWrO[0], oh(50));
        wrEn = '0;
        tick();
        chk("gate3_off", 64'(gated[3]), 64'd1);

        partGateReq[3] = 1'b0;
        tick();
        wrEn = 2'b11; wrAddr[0] = 6'd7; wrAddr[1] = 6'd60;
        rdEn[0] = 1'b1; rdAddr[0] = 6'd3;
        #1;
        chk("wake3_wr60_stall", 64'(stall), 64'd1);
        tick();
        chk("wake3_wrEn", 64'(wrEnO), 64'h1);
        chk("wake3_addrWr0", addrWrO[0], oh(7));
        chk("wake3_addrWr1", addrWrO[1], 64'd0);
        chk("wake3_addr0", addrO[0], oh(3));

        // asynchronous reset in the middle of partition 3's wake
        #2;
        reset = 1'b0;
        ramReady = 1'b0;
        rdEn = '0; wrEn = '0;
        #1;
        chk("arst_addr",   64'(addrO),   64'd0);
        chk("arst_addrWr", 64'(addrWrO), 64'd0);
        chk("arst_wrEn",   64'(wrEnO),   64'd0);
        chk("arst_rdPart", 64'(rdPart),  64'd0);
        chk("arst_gated",  64'(gated),   64'd0);
        chk("arst_ready",  64'(ready),   64'd0);
        tick();
        reset = 1'b1;
        ramReady = 1'b1;
        #1;
        chk("post_rst_ready", 64'(ready), 64'hF);
        tick();
        chk("post_rst_gated", 64'(gated), 64'd0);
        chk("post_rst_ready_hold", 64'(ready), 64'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
